// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if -- instruction memory read bus used by fetch_unit.
//
// Signals
//   imem_req    request, held high until acknowledged  (master -> slave)
//   imem_addr   16-bit word address, stable with req   (master -> slave)
//   imem_ack    acknowledge, data valid in same cycle  (slave  -> master)
//   imem_rdata  32-bit instruction word                 (slave  -> master)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- program counter, instruction fetch FSM, instruction register
// and status register.
//
// Ports
//   clk, rst_f          clock and asynchronous active-high reset
//   fetch_req           one-cycle strobe: start a fetch (honoured in IDLE only)
//   br_load/br_rel/br_addr  one-cycle PC load; relative (pc+br_addr) or absolute
//   stat_en/alu_flags   status register load
//   imem                instruction memory bus (master side)
//   ir, opcode, mm      instruction register and its top two nibbles
//   stat, pc            status register, program counter
//   ir_valid            one-cycle pulse when ir has just been loaded
//   busy                FSM not in IDLE
//   halted              sticky: a HLT (opcode 4'hF) has been fetched
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic                fetch_req,
    input  logic                br_load,
    input  logic                br_rel,
    input  logic [15:0]         br_addr,
    input  logic                stat_en,
    input  logic [3:0]          alu_flags,
    fetch_unit_if.master        imem,
    output logic [31:0]         ir,
    output logic [3:0]          opcode,
    output logic [3:0]          mm,
    output logic [3:0]          stat,
    output logic [15:0]         pc,
    output logic                ir_valid,
    output logic                busy,
    output logic                halted
);

    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  stat_q, stat_d;
    logic        halted_q, halted_d;
    logic        br_pend_q, br_pend_d;
    logic [15:0] br_tgt_q, br_tgt_d;

    // Branch target from the current pc; the 16-bit add wraps naturally.
    logic [15:0] br_target;
    assign br_target = br_rel ? (pc_q + br_addr) : br_addr;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        br_pend_d = br_pend_q;
        br_tgt_d  = br_tgt_q;
        // Status load is independent of the fetch FSM.
        stat_d    = stat_en ? alu_flags : stat_q;

        unique case (state_q)
            IDLE: begin
                // A branch in the same cycle as fetch_req lands first, so the
                // fetch addresses the new pc.
                if (br_load) pc_d = br_target;
                if (fetch_req && !halted_q) state_d = REQ;
            end
            REQ: begin
                // pc must stay put while the address is on the bus, so a
                // branch here is parked; a later one overwrites it.
                if (br_load) begin
                    br_pend_d = 1'b1;
                    br_tgt_d  = br_target;
                end
                if (imem.imem_ack) begin
                    ir_d      = imem.imem_rdata;
                    br_pend_d = 1'b0;
                    // A branch arriving with the ack is the newest one.
                    if (br_load)        pc_d = br_target;
                    else if (br_pend_q) pc_d = br_tgt_q;
                    else                pc_d = pc_q + 16'd1;
                    if (imem.imem_rdata[31:28] == OP_HLT) halted_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (br_load) pc_d = br_target;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            stat_q    <= '0;
            halted_q  <= 1'b0;
            br_pend_q <= 1'b0;
            br_tgt_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            stat_q    <= stat_d;
            halted_q  <= halted_d;
            br_pend_q <= br_pend_d;
            br_tgt_q  <= br_tgt_d;
        end
    end

    // Outputs decode straight from registers, so reset clears them at once.
    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;
    assign ir             = ir_q;
    assign opcode         = ir_q[31:28];
    assign mm             = ir_q[27:24];
    assign stat           = stat_q;
    assign pc             = pc_q;
    assign ir_valid       = (state_q == DONE);
    assign busy           = (state_q != IDLE);
    assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_req;
    logic        br_load;
    logic        br_rel;
    logic [15:0] br_addr;
    logic        stat_en;
    logic [3:0]  alu_flags;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [3:0]  stat;
    logic [15:0] pc;
    logic        ir_valid;
    logic        busy;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .fetch_req (fetch_req),
        .br_load   (br_load),
        .br_rel    (br_rel),
        .br_addr   (br_addr),
        .stat_en   (stat_en),
        .alu_flags (alu_flags),
        .imem      (imem_bus),
        .ir        (ir),
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .pc        (pc),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_f = 1'b1;
        imem_bus.imem_ack = 1'b1;   // must be ignored under reset
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 16'h0000); end
        n_vec++; if (ir !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h want %h", ir, 32'h0); end
        n_vec++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_bus.imem_req); end
        n_vec++; if ({ir_valid, busy, halted, stat} !== 7'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0", {ir_valid, busy, halted, stat}); end
        imem_bus.imem_ack = 1'b0;
        rst_f = 1'b0;
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_basic_fetch();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_vec++; if (imem_bus.imem_req !== 1'b1) begin n_err++; $display("FAIL basic_req: got %b want 1", imem_bus.imem_req); end
        n_vec++; if (imem_bus.imem_addr !== 16'h0000) begin n_err++; $display("FAIL basic_addr: got %h want 0000", imem_bus.imem_addr); end
        n_vec++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", ir_valid); end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", ir_valid); end
        n_vec++; if (opcode !== 4'h1) begin n_err++; $display("FAIL basic_opcode: got %h want 1", opcode); end
        n_vec++; if (mm !== 4'h2) begin n_err++; $display("FAIL basic_mm: got %h want 2", mm); end
        n_vec++; if (pc !== 16'h0001) begin n_err++; $display("FAIL basic_pc: got %h want 0001", pc); end
        n_vec++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_done: got %b want 0", imem_bus.imem_req); end
        step();
        n_vec++; if ({ir_valid, busy} !== 2'b00) begin n_err++; $display("FAIL basic_back_idle: got %b want 00", {ir_valid, busy}); end
    endtask

    task automatic test_ack_delay();
        int pulses = 0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (imem_bus.imem_req !== 1'b1) begin n_err++; $display("FAIL delay_req[%0d]: got %b want 1", i, imem_bus.imem_req); end
            n_vec++; if (imem_bus.imem_addr !== 16'h0001) begin n_err++; $display("FAIL delay_addr[%0d]: got %h want 0001", i, imem_bus.imem_addr); end
            if (i == 3) begin
                imem_bus.imem_ack = 1'b1;
                imem_bus.imem_rdata = 32'h2300_0000;
            end
            step();
        end
        imem_bus.imem_ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (ir_valid === 1'b1) pulses++;
            step();
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL delay_pulses: got %0d want 1", pulses); end
        n_vec++; if (pc !== 16'h0002) begin n_err++; $display("FAIL delay_pc: got %h want 0002", pc); end
        n_vec++; if (ir !== 32'h2300_0000) begin n_err++; $display("FAIL delay_ir: got %h want 23000000", ir); end
    endtask

    task automatic test_wrap();
        br_load = 1'b1; br_rel = 1'b0; br_addr = 16'hFFFE;
        step();
        br_load = 1'b0;
        n_vec++; if (pc !== 16'hFFFE) begin n_err++; $display("FAIL wrap_abs: got %h want fffe", pc); end
        br_load = 1'b1; br_rel = 1'b1; br_addr = 16'h0003;
        step();
        br_load = 1'b0; br_rel = 1'b0;
        n_vec++; if (pc !== 16'h0001) begin n_err++; $display("FAIL wrap_rel: got %h want 0001", pc); end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_vec++; if (imem_bus.imem_addr !== 16'h0001) begin n_err++; $display("FAIL wrap_fetch_addr: got %h want 0001", imem_bus.imem_addr); end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h3000_0000;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (pc !== 16'h0002) begin n_err++; $display("FAIL wrap_pc_after: got %h want 0002", pc); end
        step();
    endtask

    task automatic test_branch_in_req();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        br_load = 1'b1; br_rel = 1'b0; br_addr = 16'h0040;
        step();
        br_load = 1'b0;
        n_vec++; if (imem_bus.imem_addr !== 16'h0002) begin n_err++; $display("FAIL brreq_addr: got %h want 0002", imem_bus.imem_addr); end
        n_vec++; if (imem_bus.imem_req !== 1'b1) begin n_err++; $display("FAIL brreq_req: got %b want 1", imem_bus.imem_req); end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h4500_0000;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (pc !== 16'h0040) begin n_err++; $display("FAIL brreq_pc: got %h want 0040", pc); end
        n_vec++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL brreq_valid: got %b want 1", ir_valid); end
        step();
    endtask

    task automatic test_branch_overwrite();
        // Second pending branch is relative to pc at capture (0x40 + 5).
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        br_load = 1'b1; br_rel = 1'b0; br_addr = 16'h0010;
        step();
        br_rel = 1'b1; br_addr = 16'h0005;
        step();
        br_load = 1'b0; br_rel = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h5000_0000;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (pc !== 16'h0045) begin n_err++; $display("FAIL overwrite_pc: got %h want 0045", pc); end
        step();
    endtask

    task automatic test_same_cycle();
        fetch_req = 1'b1;
        br_load = 1'b1; br_rel = 1'b0; br_addr = 16'h0100;
        step();
        fetch_req = 1'b0; br_load = 1'b0;
        n_vec++; if (imem_bus.imem_addr !== 16'h0100) begin n_err++; $display("FAIL same_addr: got %h want 0100", imem_bus.imem_addr); end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h6000_0000;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (pc !== 16'h0101) begin n_err++; $display("FAIL same_pc: got %h want 0101", pc); end
        step();
    endtask

    task automatic test_stat();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        stat_en = 1'b1; alu_flags = 4'b1010;
        step();
        stat_en = 1'b0; alu_flags = 4'b0000;
        n_vec++; if (stat !== 4'b1010) begin n_err++; $display("FAIL stat_load: got %b want 1010", stat); end
        n_vec++; if (imem_bus.imem_req !== 1'b1) begin n_err++; $display("FAIL stat_req: got %b want 1", imem_bus.imem_req); end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h7000_0001;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (ir !== 32'h7000_0001) begin n_err++; $display("FAIL stat_ir: got %h want 70000001", ir); end
        n_vec++; if (stat !== 4'b1010) begin n_err++; $display("FAIL stat_hold: got %b want 1010", stat); end
        n_vec++; if (pc !== 16'h0102) begin n_err++; $display("FAIL stat_pc: got %h want 0102", pc); end
        stat_en = 1'b1; alu_flags = 4'b0101;
        step();
        stat_en = 1'b0;
        n_vec++; if (stat !== 4'b0101) begin n_err++; $display("FAIL stat_done: got %b want 0101", stat); end
        step();
    endtask

    task automatic test_halt();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'hF000_0000;
        step();
        imem_bus.imem_ack = 1'b0;
        n_vec++; if (opcode !== 4'hF) begin n_err++; $display("FAIL halt_opcode: got %h want f", opcode); end
        step();
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set: got %b want 1", halted); end
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_vec++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("FAIL halt_blocks_fetch: got %b want 0", imem_bus.imem_req); end
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_sticky: got %b want 1", halted); end
        rst_f = 1'b1;
        #1;
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_reset: got %b want 0", halted); end
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL halt_reset_pc: got %h want 0000", pc); end
        step();
        rst_f = 1'b0;
        step();
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n_vec++; if (imem_bus.imem_addr !== 16'h0000 || imem_bus.imem_req !== 1'b1) begin n_err++; $display("FAIL halt_refetch: got req %b addr %h want req 1 addr 0000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    // Continues from test_halt: the bus is currently in REQ at pc 0.
    task automatic test_reset_in_req();
        #2;
        rst_f = 1'b1;
        #1;
        n_vec++; if (imem_bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rstreq_drop: got %b want 0", imem_bus.imem_req); end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = 32'h9ABC_DEF0;
        step();
        imem_bus.imem_ack = 1'b0;
        rst_f = 1'b0;
        step();
        n_vec++; if (ir !== 32'h0) begin n_err++; $display("FAIL rstreq_ir: got %h want 0", ir); end
        n_vec++; if ({busy, ir_valid} !== 2'b00) begin n_err++; $display("FAIL rstreq_state: got %b want 00", {busy, ir_valid}); end
        n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL rstreq_pc: got %h want 0000", pc); end
    endtask

    initial begin
        rst_f = 1'b1;
        fetch_req = 1'b0;
        br_load = 1'b0;
        br_rel = 1'b0;
        br_addr = 16'h0;
        stat_en = 1'b0;
        alu_flags = 4'h0;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        test_reset();
        test_basic_fetch();
        test_ack_delay();
        test_wrap();
        test_branch_in_req();
        test_branch_overwrite();
        test_same_cycle();
        test_stat();
        test_halt();
        test_reset_in_req();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the PC value loaded on reset.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_f  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 fetch_req  in  1  SHALL be a one-cycle fetch request strobe from ctrl.
REQ-005 br_load  in  1  SHALL be a one-cycle PC-load strobe from ctrl.
REQ-006 br_rel  in  1  SHALL select a relative PC load (1) or an absolute PC load (0).
REQ-007 br_addr  in  16  SHALL carry the branch target or the branch offset.
REQ-008 stat_en  in  1  SHALL enable a status register load.
REQ-009 alu_flags  in  4  SHALL carry the ALU status flags.
REQ-010 imem_req  out  1  SHALL be the instruction memory read request.
REQ-011 imem_addr  out  16  SHALL be the instruction memory read address.
REQ-012 imem_ack  in  1  SHALL be the memory acknowledge, with data valid in the same cycle.
REQ-013 imem_rdata  in  32  SHALL carry the instruction word.
REQ-014 ir  out  32  SHALL be the instruction register.
REQ-015 opcode  out  4  SHALL equal ir[31:28].
REQ-016 mm  out  4  SHALL equal ir[27:24].
REQ-017 stat  out  4  SHALL be the status register.
REQ-018 pc  out  16  SHALL be the program counter.
REQ-019 ir_valid  out  1  SHALL pulse for one cycle when a new IR value is loaded.
REQ-020 busy  out  1  SHALL be high whenever the state is not IDLE.
REQ-021 halted  out  1  SHALL be a sticky flag indicating that a HLT instruction has been fetched.

Function
REQ-022 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-023 In IDLE, fetch_req=1 with halted=0 SHALL cause a transition to REQ; fetch_req SHALL be ignored in REQ, in DONE, and whenever halted=1.
REQ-024 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack=1.
REQ-025 In REQ with imem_ack=1, the block SHALL set ir<=imem_rdata, update pc per REQ-027, and go to DONE.
REQ-026 In DONE, ir_valid SHALL be 1 and imem_req SHALL be 0, with an unconditional transition to IDLE.
REQ-027 PC update on ack: pc<=pc+1 when no branch is pending; otherwise the pending branch SHALL be applied instead and the pending flag cleared.
REQ-028 A branch load SHALL compute br_rel ? pc+br_addr : br_addr, with arithmetic modulo 2^16 (wrap; 16'hFFFF+1 = 16'h0000).
REQ-029 br_load in IDLE or DONE SHALL update pc in the next cycle.
REQ-030 br_load in REQ SHALL be captured into a one-deep pending register (target computed from the pc at capture) and SHALL NOT alter imem_addr.
REQ-031 A second br_load while a branch is already pending SHALL overwrite the pending target.
REQ-032 fetch_req and br_load in the same IDLE cycle SHALL load the branch, then REQ SHALL address the new pc.
REQ-033 Latency: fetch_req at cycle N -> imem_req at N+1; an ack at N+1+k -> ir_valid at N+2+k, where k >= 0.
REQ-034 If the IR is loaded with opcode 4'hF (HLT), halted SHALL be set to 1 in the DONE cycle and remain set until reset.
REQ-035 stat_en=1 SHALL load stat<=alu_flags in the next cycle, in any FSM state and independent of the fetch logic.

Reset
REQ-036 rst_f=1 SHALL immediately force: state=IDLE, pc=RESET_PC, ir=0 (so opcode=NOOP and mm=0), stat=0, imem_req=0, ir_valid=0, halted=0, pending branch cleared.
REQ-037 Reset asserted during REQ SHALL drop imem_req asynchronously; an imem_ack arriving during reset SHALL be ignored.
REQ-038 After rst_f is deasserted, the first fetch SHALL read address RESET_PC.

Verification
REQ-039 Reset, then fetch_req with imem_ack 0 cycles late and imem_rdata=32'h1234_5678 -> imem_addr=0, ir_valid one cycle later, opcode=1, mm=2, pc=1.
REQ-040 Ack delayed 3 cycles -> imem_req held high and imem_addr constant for 4 cycles, exactly one ir_valid pulse.
REQ-041 pc=16'hFFFE, br_load with br_rel=1 and br_addr=3 in IDLE -> pc=16'h0001; then a fetch reads address 1.
REQ-042 br_load (absolute, 16'h0040) during REQ, then ack -> imem_addr unchanged during REQ, and pc=16'h0040 (not pc+1) after ack.
REQ-043 Fetch returns 32'hF000_0000 -> halted=1; a subsequent fetch_req leaves imem_req=0; rst_f pulse -> halted=0, pc=RESET_PC.
REQ-044 stat_en=1 with alu_flags=4'b1010 during REQ -> stat=4'b1010 next cycle, with the fetch completing normally.
